// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin selector: first set bit of req at or after start, wrapping.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan N candidates starting at the pointer; the first requester found wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(start) + i) % N);
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
// Optional per-requester beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]           fifo_w_data,
  output logic                       fifo_w_enable,
  input  logic                       fifo_full,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [N_REQ*STAT_W-1:0]    stat_beats
`endif
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            xfer;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             unused_pick_gnt;

  logic [WIDTH-1:0] req_data_a [N_REQ];

  // Unpack the flat data bus so the granted lane can be selected by index.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_data_a[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req   (req_valid),
    .start (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The binary index drives the grant; the one-hot form is not needed here.
  assign unused_pick_gnt = ^pick_gnt;

  // Next-state, grant bookkeeping and the combinational write datapath.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    req_ready     = '0;
    fifo_w_enable = 1'b0;
    fifo_w_data   = '0;
    xfer          = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_q] = !fifo_full;
        fifo_w_enable      = req_valid[grant_q] & !fifo_full;
        fifo_w_data        = req_data_a[grant_q];
        xfer               = fifo_w_enable;
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (req_last[grant_q] || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q == BURST);
  assign grant_id = grant_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N_REQ];
  logic [STAT_W-1:0] stat_d [N_REQ];
  logic [N_REQ-1:0]  xfer_vec;

  assign xfer_vec = req_valid & req_ready;

  // Saturating per-requester beat counters; clear wins over a same-cycle beat.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (xfer_vec[i] && (stat_q[i] != STAT_MAX)) begin
        stat_d[i] = stat_q[i] + STAT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) stat_q[i] <= stat_d[i];
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat_out
    assign stat_beats[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one asynchronous FIFO among `N_REQ` requesters, all in the FIFO's write clock domain. The arbiter grants one requester at a time for a burst. A burst ends on the requester's `last` beat or after `MAX_BURST` beats. Back-pressure comes from the FIFO's registered full flag. The block sits directly in front of the FIFO write port, replacing per-source write logic.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, minimum 2.
- `WIDTH`, default 8: data width, matches the FIFO.
- `MAX_BURST`, default 8: maximum beats per grant, minimum 1.

Ports (reset is `aresetn`, asynchronous, active-low; clock is `clk`):
- `clk`  in  1  write-domain clock, same as the FIFO write clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_data`  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `req_last`  in  N_REQ  last beat of the requester's packet.
- `req_ready`  out  N_REQ  beat accepted when valid & ready.
- `fifo_w_data`  out  WIDTH  to the FIFO write data.
- `fifo_w_enable`  out  1  to the FIFO write enable.
- `fifo_full`  in  1  from the FIFO full flag.
- `grant_id`  out  clog2(N_REQ)  current or last granted requester.
- `busy`  out  1  high in BURST.

## Operation
- FSM states are IDLE and BURST. Reset state is IDLE.
- IDLE: if any `req_valid` is high, pick the winner by round-robin, starting the search at `rr_ptr`. Register `grant_id`, clear `beat_cnt`, and move to BURST. With no valid requests, remain in IDLE.
- BURST outputs:
  - `req_ready[grant_id] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_w_enable = req_valid[grant_id] & !fifo_full`.
  - `fifo_w_data` = the granted requester's data.
- Transfer is `req_valid[grant_id] & req_ready[grant_id]`. On each transfer, `beat_cnt` increments.
- A transfer with `req_last` set, or with `beat_cnt == MAX_BURST-1`, ends the burst:
  - the FSM goes to IDLE;
  - `rr_ptr` becomes `(grant_id+1) mod N_REQ`.
- A MAX_BURST cut does not require `req_last`. The requester resumes its packet on a later grant.
- Inside a burst, the granted requester may deassert `req_valid`. The grant is held, with no timeout.
- Outside BURST, `req_ready` is all zeros and `fifo_w_enable` is 0.
- The arbiter never asserts `fifo_w_enable` while `fifo_full` is high. The FIFO therefore sees no dropped writes.
- `beat_cnt` width is clog2(MAX_BURST+1). `rr_ptr` and `grant_id` are clog2(N_REQ) wide, and wrap from N_REQ-1 to 0.

## Timing
- Reset values:
  - `req_ready` = 0, `fifo_w_enable` = 0, `fifo_w_data` = 0, `busy` = 0, `grant_id` = 0;
  - internally, `rr_ptr` = 0 and `beat_cnt` = 0.
- Arbitration takes 1 cycle. A request first seen in IDLE at edge n is granted at edge n+1, and the first beat can transfer in cycle n+1.
- A burst end at edge m returns the FSM to IDLE, so there is a 1-cycle bubble before the next grant.
- Datapath is combinational, with no pipeline register: `fifo_w_enable` and `fifo_w_data` follow the requester inputs and `fifo_full` in the same cycle.
- `fifo_full` rising mid-burst stalls the burst with no state change. The burst resumes on the first cycle `fifo_full` is low.
- Reset asserted mid-burst: all state returns to reset values immediately. Partial packets are not tracked or resumed.

## Configuration
- Macro `FIFO_ARB_STATS_EN`.
- With the macro defined:
  - adds output `stat_beats`, N_REQ*16 bits, with requester i at [i*16 +: 16];
  - each counter increments on every transfer for that requester and saturates at 16'hFFFF;
  - adds input `stat_clr`, 1 bit, which zeros all counters synchronously;
  - `stat_clr` takes priority over the same-cycle increment;
  - counters reset to 0.
- Without the macro, neither port exists and there is no counter logic.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, BURST);
  - `STAT_W = 16` and `STAT_MAX = 16'hFFFF`.
- Sub-module `rr_picker`: combinational round-robin selector.
  - Inputs: `req` vector and `start` pointer.
  - Outputs: one-hot `gnt`, binary `idx`, and `any`.
- Top level: FSM, counters, mux, and stats.

## Test plan
- Requester 2 alone sends 3 beats (A1, A2, A3-last) with `fifo_full`=0. Expect grant at cycle 1, three consecutive writes A1..A3, IDLE after A3, `rr_ptr`=3.
- Requesters 0 and 1 both request continuously with 1-beat packets. Expect grants alternating 0,1,0,1, each followed by an idle bubble, and exactly one writer per burst.
- MAX_BURST=4, requester 0 sends a 6-beat packet while requester 1 waits. Expect 4 beats from requester 0, then requester 1's burst, then the remaining 2 beats from requester 0.
- `fifo_full` is held high for 5 cycles mid-burst. Expect `fifo_w_enable`=0 and `req_ready`=0 during those cycles, no beat lost or duplicated, and resumption on the cycle full drops.
- `aresetn` is pulsed low during beat 2 of a 4-beat burst. Expect all outputs at reset values and IDLE. After release, the re-request wins with `grant_id` from `rr_ptr`=0.
- With `FIFO_ARB_STATS_EN`: 70000 transfers from requester 1 give `stat_beats[1]` = 16'hFFFF, and a `stat_clr` pulse returns it to 0.
